// File: rtl/wave_uart_pkg.sv
// Shared types and constants for the waveform UART receiver.
package wave_uart_pkg;

  localparam int NUM_SAMPLES = 32;
  localparam int SAMPLE_W    = 14;
  localparam int IDX_W       = 5;
  localparam int MARKER_BIT  = 5;

  typedef logic [SAMPLE_W-1:0] sample_t;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;

  typedef enum logic [1:0] {B0, B1, B2} rec_state_t;

  // Record bytes 0 and 1 carry the upper 6 and lower 8 sample bits.
  function automatic sample_t pack_sample(input logic [5:0] hi, input logic [7:0] lo);
    return {hi, lo};
  endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: two-flop rx synchronizer, falling-edge start detect, mid-bit sampling.
// Latency: byte_valid/framing_error pulse one clk after the stop-bit sample point.
// Backpressure: none; each byte is presented for a single cycle and must be consumed.
module uart_rx_byte
  import wave_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       framing_error,
  output logic       start_edge
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic rx_meta;
  logic rx_sync;
  logic rx_prev;
  logic fall;

  rx_state_t     state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  // Left out of reset so a line held low through reset is already settled
  // when reset releases and cannot look like a start edge.
  always_ff @(posedge clk) begin
    rx_meta <= rx;
    rx_sync <= rx_meta;
    rx_prev <= rx_sync;
  end

  assign fall = rx_prev & ~rx_sync;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      byte_data     <= '0;
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      start_edge    <= 1'b0;
    end else begin
      byte_valid    <= 1'b0;
      framing_error <= 1'b0;
      start_edge    <= 1'b0;
      case (state)
        IDLE: begin
          if (fall) begin
            state      <= START;
            cnt        <= '0;
            start_edge <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_sync ? IDLE : DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt     <= '0;
            shreg   <= {rx_sync, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt   <= '0;
            state <= IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              byte_data  <= shreg;
            end else begin
              framing_error <= 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/waveform_uart_receiver.sv
// Decodes 3-byte UART sample records and stores each 14-bit sample in a 32-entry array.
// Latency: array write and sample_valid one clk after the third byte completes.
// Backpressure: none; the serial link is free-running and every record is applied as it lands.
module waveform_uart_receiver
  import wave_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int IDLE_TIMEOUT = 20
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                rx,
  input  logic                clear,
  output logic [SAMPLE_W-1:0] waveform [NUM_SAMPLES],
  output logic                sample_valid,
  output logic [IDX_W-1:0]    sample_index,
  output logic [SAMPLE_W-1:0] sample_data,
  output logic                waveform_done,
  output logic                framing_error,
  output logic                marker_error
);

  localparam int TO_CLKS = IDLE_TIMEOUT * CLKS_PER_BIT;
  localparam int TW      = $clog2(TO_CLKS + 1);
  localparam logic [TW-1:0]    TO_LAST  = TW'(TO_CLKS - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SAMPLES - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       start_edge;

  rec_state_t     rec_state;
  logic [5:0]     hi;
  logic [7:0]     lo;
  logic [TW-1:0]  to_cnt;
  logic [IDX_W-1:0] rec_idx;

  uart_rx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .byte_valid   (byte_valid),
    .byte_data    (byte_data),
    .framing_error(framing_error),
    .start_edge   (start_edge)
  );

  assign rec_idx = byte_data[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rec_state     <= B0;
      hi            <= '0;
      lo            <= '0;
      to_cnt        <= '0;
      sample_valid  <= 1'b0;
      sample_index  <= '0;
      sample_data   <= '0;
      waveform_done <= 1'b0;
      marker_error  <= 1'b0;
      for (int i = 0; i < NUM_SAMPLES; i++) waveform[i] <= '0;
    end else begin
      sample_valid  <= 1'b0;
      waveform_done <= 1'b0;
      marker_error  <= 1'b0;

      // Idle timer only runs while a record is partially assembled.
      if (rec_state == B0 || start_edge || byte_valid) to_cnt <= '0;
      else                                             to_cnt <= to_cnt + 1'b1;

      if (clear) begin
        rec_state <= B0;
        for (int i = 0; i < NUM_SAMPLES; i++) waveform[i] <= '0;
      end else if (framing_error) begin
        rec_state <= B0;
      end else if (byte_valid) begin
        case (rec_state)
          B0: begin
            hi        <= byte_data[5:0];
            rec_state <= B1;
          end
          B1: begin
            lo        <= byte_data;
            rec_state <= B2;
          end
          B2: begin
            rec_state <= B0;
            if (byte_data[MARKER_BIT]) begin
              waveform[rec_idx] <= pack_sample(hi, lo);
              sample_valid      <= 1'b1;
              sample_index      <= rec_idx;
              sample_data       <= pack_sample(hi, lo);
              waveform_done     <= (rec_idx == LAST_IDX);
            end else begin
              marker_error <= 1'b1;
            end
          end
          default: rec_state <= B0;
        endcase
      end else if (rec_state != B0 && to_cnt == TO_LAST) begin
        rec_state <= B0;
      end
    end
  end

endmodule

// File: tb/tb_waveform_uart_receiver.sv
// Scoreboard bench for waveform_uart_receiver at 4 clocks per bit.
module tb_waveform_uart_receiver;

  localparam int CPB = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;
  logic        clear = 1'b0;
  logic [13:0] waveform [32];
  logic        sample_valid;
  logic [4:0]  sample_index;
  logic [13:0] sample_data;
  logic        waveform_done;
  logic        framing_error;
  logic        marker_error;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int me_cnt = 0;
  int done_cnt = 0;

  logic [13:0] model [32];
  logic [19:0] exp_q [$];
  logic [19:0] got_q [$];

  always #5 clk = ~clk;

  waveform_uart_receiver #(
    .CLKS_PER_BIT(CPB),
    .IDLE_TIMEOUT(20)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rx           (rx),
    .clear        (clear),
    .waveform     (waveform),
    .sample_valid (sample_valid),
    .sample_index (sample_index),
    .sample_data  (sample_data),
    .waveform_done(waveform_done),
    .framing_error(framing_error),
    .marker_error (marker_error)
  );

  always @(negedge clk) begin
    if (sample_valid) got_q.push_back({waveform_done, sample_index, sample_data});
    if (framing_error) fe_cnt++;
    if (marker_error) me_cnt++;
    if (waveform_done) done_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    rx = stop_bit;
    repeat (CPB) @(negedge clk);
    rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_record(input logic [4:0] idx, input logic [13:0] s);
    exp_q.push_back({(idx == 5'd31), idx, s});
    model[idx] = s;
    send_byte({2'b00, s[13:8]});
    send_byte(s[7:0]);
    send_byte({3'b001, idx});
  endtask

  task automatic check_writes(input string name);
    int waited = 0;
    logic [19:0] e, g;
    while (got_q.size() < exp_q.size() && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if (got_q.size() == 0) begin
        fails++;
        $display("FAIL %s: no write seen, expected idx=%0d data=%h done=%b", name, e[18:14], e[13:0], e[19]);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin
          fails++;
          $display("FAIL %s: got idx=%0d data=%h done=%b, expected idx=%0d data=%h done=%b",
                   name, g[18:14], g[13:0], g[19], e[18:14], e[13:0], e[19]);
        end
      end
    end
    tests++;
    if (got_q.size() != 0) begin
      fails++;
      $display("FAIL %s_extra: %0d unexpected writes, expected 0 (first idx=%0d data=%h)",
               name, got_q.size(), got_q[0][18:14], got_q[0][13:0]);
      got_q.delete();
    end
  endtask

  task automatic check_array(input string name);
    int bad = -1;
    for (int i = 0; i < 32; i++) if (bad < 0 && waveform[i] !== model[i]) bad = i;
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s: waveform[%0d]=%h, expected %h", name, bad, waveform[bad], model[bad]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (4) @(negedge clk);
    tests++;
    if ({sample_valid, sample_index, sample_data, waveform_done, framing_error, marker_error} !== 23'd0) begin
      fails++;
      $display("FAIL reset_outputs: valid=%b idx=%0d data=%h done=%b fe=%b me=%b, expected all 0",
               sample_valid, sample_index, sample_data, waveform_done, framing_error, marker_error);
    end
    check_array("reset_array");
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic test_single();
    int fe0 = fe_cnt, me0 = me_cnt;
    send_record(5'd3, 14'h2ABC);
    check_writes("single_write");
    check_array("single_array");
    tests++;
    if (fe_cnt !== fe0 || me_cnt !== me0) begin
      fails++;
      $display("FAIL single_errors: fe=%0d me=%0d, expected 0 0", fe_cnt - fe0, me_cnt - me0);
    end
  endtask

  task automatic test_full();
    int d0 = done_cnt;
    for (int i = 0; i < 32; i++) send_record(5'(i), 14'(14'h1000 + i));
    check_writes("full_write");
    check_array("full_array");
    tests++;
    if (done_cnt - d0 !== 1) begin
      fails++;
      $display("FAIL full_done_count: got %0d waveform_done pulses, expected 1", done_cnt - d0);
    end
  endtask

  task automatic test_framing();
    int fe0 = fe_cnt;
    send_byte(8'h10);
    send_byte(8'h55, 1'b0);
    send_record(5'd5, 14'h0102);
    check_writes("framing_write");
    check_array("framing_array");
    tests++;
    if (fe_cnt - fe0 !== 1) begin
      fails++;
      $display("FAIL framing_pulse: got %0d framing_error pulses, expected 1", fe_cnt - fe0);
    end
  endtask

  task automatic test_marker();
    int me0 = me_cnt;
    send_byte(8'h3F);
    send_byte(8'hFF);
    send_byte(8'h03);
    send_record(5'd9, 14'h3A5C);
    check_writes("marker_write");
    check_array("marker_array");
    tests++;
    if (me_cnt - me0 !== 1) begin
      fails++;
      $display("FAIL marker_pulse: got %0d marker_error pulses, expected 1", me_cnt - me0);
    end
  endtask

  task automatic test_glitch_reset();
    int fe0 = fe_cnt, me0 = me_cnt;
    logic [7:0] b = 8'hC3;
    rx = 1'b0;
    @(negedge clk);
    rx = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    send_record(5'd12, 14'h0777);
    check_writes("glitch_write");
    tests++;
    if (fe_cnt !== fe0 || me_cnt !== me0) begin
      fails++;
      $display("FAIL glitch_errors: fe=%0d me=%0d, expected 0 0", fe_cnt - fe0, me_cnt - me0);
    end
    send_byte(8'h11);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      repeat (CPB) @(negedge clk);
    end
    reset_n = 1'b0;
    rx = 1'b1;
    for (int i = 0; i < 32; i++) model[i] = '0;
    repeat (3) @(negedge clk);
    tests++;
    if ({sample_valid, sample_index, sample_data, waveform_done, framing_error, marker_error} !== 23'd0) begin
      fails++;
      $display("FAIL midreset_outputs: valid=%b idx=%0d data=%h done=%b fe=%b me=%b, expected all 0",
               sample_valid, sample_index, sample_data, waveform_done, framing_error, marker_error);
    end
    check_array("midreset_array");
    reset_n = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    send_record(5'd20, 14'h1234);
    check_writes("postreset_write");
    check_array("postreset_array");
  endtask

  task automatic test_clear_timeout();
    logic [7:0] b2 = 8'h27;
    send_record(5'd2, 14'h0ABC);
    check_writes("preclear_write");
    send_byte(8'h05);
    send_byte(8'h55);
    rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b2[i];
      repeat (CPB) @(negedge clk);
    end
    rx = 1'b1;
    repeat (CPB) @(negedge clk);
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    for (int i = 0; i < 32; i++) model[i] = '0;
    tests++;
    if (sample_valid !== 1'b0) begin
      fails++;
      $display("FAIL clear_valid: sample_valid=%b in clear cycle, expected 0", sample_valid);
    end
    repeat (2 * CPB) @(negedge clk);
    check_writes("clear_nowrite");
    check_array("clear_array");
    send_byte(8'h3F);
    repeat (25 * CPB) @(negedge clk);
    send_record(5'd17, 14'h2DEF);
    check_writes("timeout_write");
    check_array("timeout_array");
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_single();
    test_full();
    test_framing();
    test_marker();
    test_glitch_reset();
    test_clear_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
